// File: rtl/ext_uart_pkg.sv
// ext_uart_pkg: register offsets, STATUS bit positions and FSM encoding
// shared by the ext_uart_tx transmitter and its FIFO.
package ext_uart_pkg;

    localparam logic [1:0] OFF_TXDATA  = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_BAUDDIV = 2'd2;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;
    localparam int ST_DONE  = 4;
    localparam int ST_COUNT = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/ext_uart_tx_if.sv
// ext_uart_tx_if: external bus of the MIPS system as seen by the UART.
// master = CPU/memory side, slave = peripheral side.
interface ext_uart_tx_if;

    logic        ext_write_en;
    logic        ext_read_en;
    logic [31:0] ext_addr;
    logic [31:0] ext_write_data;
    logic [31:0] ext_data_out;

    modport master (
        output ext_write_en,
        output ext_read_en,
        output ext_addr,
        output ext_write_data,
        input  ext_data_out
    );

    modport slave (
        input  ext_write_en,
        input  ext_read_en,
        input  ext_addr,
        input  ext_write_data,
        output ext_data_out
    );

endinterface

// File: rtl/ext_uart_fifo.sv
// ext_uart_fifo: synchronous circular byte FIFO, depth 2**AW.
// Push while full and pop while empty are ignored.
module ext_uart_fifo #(
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [7:0]   din,
    input  logic         pop,
    output logic [7:0]   dout,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count
);

    localparam int DEPTH = 1 << AW;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // count never exceeds DEPTH, so its MSB alone marks full
    assign full    = count[AW];
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ext_uart_tx.sv
// ext_uart_tx: memory-mapped 8N1 UART transmitter with byte FIFO.
// Define EXT_UART_TX_IRQ_EN to add STATUS.done_pending and the irq output.
module ext_uart_tx
    import ext_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
    parameter int          FIFO_AW     = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic         clk,
    input  logic         rst,
    ext_uart_tx_if.slave bus,
`ifdef EXT_UART_TX_IRQ_EN
    output logic         irq,
`endif
    output logic         uart_tx
);

    logic              hit;
    logic [1:0]        off;
    logic              wr_hit;
    logic              push_req;
    logic              st_wr;
    logic              div_wr;

    logic              fifo_full;
    logic              fifo_empty;
    logic [FIFO_AW:0]  fifo_count;
    logic [7:0]        fifo_dout;
    logic              pop;

    logic [15:0]       div_q;
    logic              ovf_q;
    logic              done_q;
    logic [31:0]       status;

    tx_state_e         state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              leave_stop;

    assign hit      = (bus.ext_addr[31:4] == BASE_ADDR[31:4]);
    assign off      = bus.ext_addr[3:2];
    assign wr_hit   = bus.ext_write_en & hit;
    assign push_req = wr_hit & (off == OFF_TXDATA);
    assign st_wr    = wr_hit & (off == OFF_STATUS);
    assign div_wr   = wr_hit & (off == OFF_BAUDDIV);

    ext_uart_fifo #(
        .AW(FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .din   (bus.ext_write_data[7:0]),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // full is the pre-edge value, so a push onto a full FIFO is
    // dropped even when the FSM pops in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= DEFAULT_DIV;
            ovf_q <= 1'b0;
        end else begin
            if (div_wr) begin
                div_q <= bus.ext_write_data[15:0];
            end
            if (push_req && fifo_full) begin
                ovf_q <= 1'b1;
            end else if (st_wr && bus.ext_write_data[ST_OVF]) begin
                ovf_q <= 1'b0;
            end
        end
    end

`ifdef EXT_UART_TX_IRQ_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q <= 1'b0;
        end else if (leave_stop && fifo_empty) begin
            done_q <= 1'b1;
        end else if (st_wr && bus.ext_write_data[ST_DONE]) begin
            done_q <= 1'b0;
        end
    end

    assign irq = done_q;

    logic unused_bits;
    assign unused_bits = ^{bus.ext_write_data[31:16], bus.ext_addr[1:0]};
`else
    assign done_q = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{bus.ext_write_data[31:16], bus.ext_addr[1:0],
                           leave_stop};
`endif

    always_comb begin
        status                          = '0;
        status[ST_FULL]                 = fifo_full;
        status[ST_EMPTY]                = fifo_empty;
        status[ST_BUSY]                 = (state_q != S_IDLE);
        status[ST_OVF]                  = ovf_q;
        status[ST_DONE]                 = done_q;
        status[ST_COUNT +: FIFO_AW+1]   = fifo_count;
    end

    always_comb begin
        bus.ext_data_out = '0;
        if (bus.ext_read_en && hit) begin
            unique case (off)
                OFF_STATUS:  bus.ext_data_out = status;
                OFF_BAUDDIV: bus.ext_data_out = {16'h0, div_q};
                default:     bus.ext_data_out = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // the baud counter reloads from the live divisor at each bit start,
    // so a divisor write mid-frame applies from the next bit onward
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        pop        = 1'b0;
        leave_stop = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    cnt_d   = div_q;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    cnt_d   = div_q;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = div_q;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                if (cnt_q == '0) begin
                    leave_stop = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
        endcase
    end

    // line level follows the next state so it is registered glitch-free
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign uart_tx = tx_q;

endmodule

// File: tb/tb_ext_uart_tx.sv
// tb_ext_uart_tx: directed and randomized checks of ext_uart_tx against
// a frame-level line model and a byte queue.
module tb_ext_uart_tx;

    localparam logic [31:0] BASE  = 32'hFFFF_0000;
    localparam logic [31:0] A_TX  = BASE + 32'h0;
    localparam logic [31:0] A_ST  = BASE + 32'h4;
    localparam logic [31:0] A_DIV = BASE + 32'h8;
    localparam logic [31:0] A_RSV = BASE + 32'hC;
`ifdef EXT_UART_TX_IRQ_EN
    localparam logic [31:0] DONE_BIT = 32'h10;
`else
    localparam logic [31:0] DONE_BIT = 32'h0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic uart_tx;
`ifdef EXT_UART_TX_IRQ_EN
    logic irq;
`endif

    int tests = 0;
    int fails = 0;

    ext_uart_tx_if bus();

    ext_uart_tx #(
        .BASE_ADDR   (BASE),
        .FIFO_AW     (4),
        .DEFAULT_DIV (16'd433)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
`ifdef EXT_UART_TX_IRQ_EN
        .irq     (irq),
`endif
        .uart_tx (uart_tx)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.ext_addr       = a;
        bus.ext_write_data = d;
        bus.ext_write_en   = 1'b1;
        @(negedge clk);
        bus.ext_write_en   = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.ext_addr    = a;
        bus.ext_read_en = 1'b1;
        #1;
        d = bus.ext_data_out;
        bus.ext_read_en = 1'b0;
    endtask

    // line level t clocks after the start bit began: start, 8 data, stop
    function automatic logic exp_line(input logic [7:0] b, input int d,
                                      input int t);
        int idx;
        idx = t / (d + 1);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] st_model(input int cnt, input bit busy,
                                             input bit ovf);
        logic [31:0] r;
        logic [4:0]  c;
        c       = 5'(cnt);
        r       = '0;
        r[0]    = (cnt == 16);
        r[1]    = (cnt == 0);
        r[2]    = busy;
        r[3]    = ovf;
        r[12:8] = c;
        return r;
    endfunction

    task automatic wait_start(input string tag, input int bound);
        for (int i = 0; i < bound && uart_tx !== 1'b0; i++) begin
            @(negedge clk);
        end
        check(tag, {31'b0, uart_tx}, 32'h0);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] b,
                             input int d);
        logic [31:0] s;
        for (int t = 0; t < 10 * (d + 1); t++) begin
            if (t > 0) @(negedge clk);
            check(tag, {31'b0, uart_tx}, {31'b0, exp_line(b, d, t)});
            if (t % (d + 1) == 0) begin
                rd(A_ST, s);
                check({tag, "_busy"}, {31'b0, s[2]}, 32'h1);
            end
        end
    endtask

    initial begin
        logic [31:0] s;
        logic [7:0]  b;
        logic [7:0]  q[$];
        int          d;

        bus.ext_write_en   = 1'b0;
        bus.ext_read_en    = 1'b0;
        bus.ext_addr       = '0;
        bus.ext_write_data = '0;

        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_tx", {31'b0, uart_tx}, 32'h1);
`ifdef EXT_UART_TX_IRQ_EN
        check("rst_irq", {31'b0, irq}, 32'h0);
`endif
        rd(A_ST, s);
        check("rst_status", s, st_model(0, 0, 0));
        rd(A_DIV, s);
        check("rst_div", s, 32'd433);
        bus.ext_addr = A_DIV;
        #1;
        check("no_strobe", bus.ext_data_out, 32'h0);
        rd(A_TX, s);
        check("txdata_rd", s, 32'h0);

        wr(A_DIV, 32'hABCD_0003);
        rd(A_DIV, s);
        check("div_upper", s, 32'h3);
        wr(A_TX, 32'h0000_12A5);
        wait_start("a5_start", 8);
        run_frame("a5", 8'hA5, 3);
        @(negedge clk);
        check("a5_idle", {31'b0, uart_tx}, 32'h1);
        rd(A_ST, s);
        check("a5_status", s, st_model(0, 0, 0) | DONE_BIT);
`ifdef EXT_UART_TX_IRQ_EN
        check("a5_irq", {31'b0, irq}, 32'h1);
`endif
        wr(A_ST, 32'h10);
        rd(A_ST, s);
        check("done_clr", s, st_model(0, 0, 0));
`ifdef EXT_UART_TX_IRQ_EN
        check("irq_clr", {31'b0, irq}, 32'h0);
`endif

        for (int k = 0; k < 5; k++) begin
            d = (k == 0) ? 0 : int'($urandom_range(0, 5));
            b = 8'($urandom);
            wr(A_DIV, d);
            wr(A_TX, {24'h0, b});
            wait_start("rnd_start", 8);
            run_frame("rnd", b, d);
            @(negedge clk);
            wr(A_ST, 32'h10);
        end

        wr(A_DIV, 32'd1);
        wr(A_TX, 32'h00);
        wr(A_TX, 32'hFF);
        wait_start("b2b_start", 8);
        run_frame("b2b_f1", 8'h00, 1);
        @(negedge clk);
        check("b2b_gap", {31'b0, uart_tx}, 32'h1);
        @(negedge clk);
        run_frame("b2b_f2", 8'hFF, 1);
        @(negedge clk);
        wr(A_ST, 32'h10);

        wr(A_DIV, 32'd100);
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            wr(A_TX, {24'h0, b});
        end
        rd(A_ST, s);
        check("fill_status", s, st_model(16, 1, 0));
        wr(A_TX, 32'h0000_005A);
        rd(A_ST, s);
        check("ovf_status", s, st_model(16, 1, 1));
        wr(A_ST, 32'h8);
        rd(A_ST, s);
        check("ovf_clr", s, st_model(16, 1, 0));

        void'(q.pop_front());
        wr(A_DIV, 32'd0);
        rd(A_ST, s);
        for (int i = 0; i < 1200 && s[12:8] != 5'd15; i++) begin
            @(negedge clk);
            rd(A_ST, s);
        end
        check("fill_pop", {27'b0, s[12:8]}, 32'd15);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) begin
                @(negedge clk);
                check("order_gap", {31'b0, uart_tx}, 32'h1);
                @(negedge clk);
            end
            b = q.pop_front();
            run_frame("order", b, 0);
        end
        @(negedge clk);
        rd(A_ST, s);
        check("drain_status", s, st_model(0, 0, 0) | DONE_BIT);
        wr(A_ST, 32'h10);

        wr(A_DIV, 32'd7);
        wr(A_TX, 32'h00);
        wait_start("mid_start", 8);
        wr(A_TX, 32'h33);
        wr(A_TX, 32'h44);
        repeat (33) @(negedge clk);
        check("mid_bit3", {31'b0, uart_tx}, 32'h0);
        #2 rst = 1'b0;
        #1;
        check("mid_async", {31'b0, uart_tx}, 32'h1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rd(A_ST, s);
        check("mid_status", s, st_model(0, 0, 0));
        rd(A_DIV, s);
        check("mid_div", s, 32'd433);
        repeat (5) @(negedge clk);
        check("mid_quiet", {31'b0, uart_tx}, 32'h1);

        rd(BASE + 32'hC, s);
        check("rd_rsv", s, 32'h0);
        rd(32'h0000_1004, s);
        check("rd_outside", s, 32'h0);
        wr(BASE + 32'h20, 32'h55);
        wr(32'h0000_1008, 32'h5);
        wr(A_RSV, 32'h1234);
        rd(A_ST, s);
        check("dec_status", s, st_model(0, 0, 0));
        rd(A_DIV, s);
        check("dec_div", s, 32'd433);
        rd(A_RSV, s);
        check("dec_rsv", s, 32'h0);
        repeat (3) @(negedge clk);
        check("dec_tx", {31'b0, uart_tx}, 32'h1);

        bus.ext_addr       = A_DIV;
        bus.ext_write_data = 32'd9;
        bus.ext_write_en   = 1'b1;
        bus.ext_read_en    = 1'b1;
        #1;
        check("rw_old", bus.ext_data_out, 32'd433);
        @(negedge clk);
        bus.ext_write_en = 1'b0;
        bus.ext_read_en  = 1'b0;
        rd(A_DIV, s);
        check("rw_new", s, 32'd9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ext_uart_tx.md
Name: ext_uart_tx

Overview:
- Memory-mapped UART transmitter on the external bus of the MIPS system: ext_write_en, ext_read_en, ext_addr, ext_write_data and ext_data_in.
- Sits directly downstream of the CPU/memory system.
- The CPU writes bytes into an internal FIFO; a bit-serial FSM shifts them out 8N1 on uart_tx.
- Status and baud divisor are readable back through the same bus.

Parameters:
- BASE_ADDR, 32'hFFFF_0000: register window base; decode ext_addr[31:4] == BASE_ADDR[31:4].
- FIFO_AW, 4: FIFO address width; depth = 2**FIFO_AW = 16 entries.
- DEFAULT_DIV, 16'd433: reset value of the baud divisor; bit period = DIV+1 clocks.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- ext_write_en  in  1  bus write strobe, single cycle per access.
- ext_read_en  in  1  bus read strobe.
- ext_addr  in  32  byte address; offset = ext_addr[3:2].
- ext_write_data  in  32  write data.
- ext_data_out  out  32  read data; system connects it to its ext_data_in.
- uart_tx  out  1  serial line, idle high.

Behaviour:
- Registers (offset ext_addr[3:2]):
  - 0 TXDATA: write pushes ext_write_data[7:0]; reads 0.
  - 1 STATUS, read-only except W1C bits:
    - [0] full, [1] empty, [2] busy (FSM not IDLE), [3] overflow (sticky).
    - [8+:FIFO_AW+1] count; others 0.
    - Writing 1 to bit 3 clears overflow.
  - 2 BAUDDIV: [15:0] read/write; upper bits read 0.
  - 3: reserved; reads 0, writes ignored.
- Out-of-window or reserved accesses are ignored, with no side effects.
- Read path:
  - ext_data_out is combinational: selected register when ext_read_en is high and the address hits the window, else 32'h0.
  - Zero-latency, same cycle as ext_read_en.
- Write path: the register update or FIFO push is visible on the next clk edge. One access per cycle; ext_read_en and ext_write_en together → write performed, read mux still driven.
- Push when full:
  - Byte dropped; overflow set.
  - Full is evaluated on the pre-edge count, so a push while full is dropped even if a pop occurs in the same cycle.
- Push and pop in the same cycle when not full: both occur; count unchanged.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: uart_tx=1. If FIFO non-empty, pop head into the shift register, load the baud counter with DIV, go to START.
  - START: uart_tx=0 for DIV+1 clocks, then DATA with bit index 0.
  - DATA: uart_tx=shift[0], LSB first. Each bit is held DIV+1 clocks; shift right after each bit. After bit 7, go to STOP.
  - STOP: uart_tx=1 for DIV+1 clocks, then IDLE. The next byte's START begins one clock later (IDLE pop cycle).
- Baud counter:
  - Reloads from the live BAUDDIV at every bit start and counts down to 0.
  - A BAUDDIV write mid-frame takes effect at the next bit boundary.
  - DIV=0 gives 1 clock/bit.
- FIFO: circular, pointers wrap modulo depth; count is FIFO_AW+1 bits (0..16).
- Reset values (async on rst=0):
  - uart_tx=1, FSM=IDLE, FIFO empty (pointers/count 0), overflow=0, BAUDDIV=DEFAULT_DIV.
  - ext_data_out is combinational and reads 0 with no strobe.
- Reset mid-frame aborts the frame immediately: line goes high asynchronously and FIFO contents are discarded.

Optional Feature:
- Macro: EXT_UART_TX_IRQ_EN.
- With the macro defined:
  - Adds output port irq (1 bit) and STATUS bit [4] done_pending.
  - done_pending is set in the cycle the FSM leaves STOP with the FIFO empty; it is cleared by writing 1 to STATUS bit 4.
  - irq = done_pending, registered; reset 0.
  - A set and a clear in the same cycle → set wins.
- Without the macro: no irq port; STATUS bit 4 reads 0; writes to it are ignored.

Decomposition:
- Package ext_uart_pkg:
  - Register offsets (OFF_TXDATA=2'd0, OFF_STATUS=2'd1, OFF_BAUDDIV=2'd2).
  - STATUS bit positions.
  - FSM state encoding (2-bit: IDLE, START, DATA, STOP).
- One natural sub-module: ext_uart_fifo, a synchronous FIFO with 8-bit data, FIFO_AW parameter, push/pop/full/empty/count.
- FSM, baud counter and register decode stay in ext_uart_tx.

Test Plan:
- Reset then idle: rst low 3 cycles, release → uart_tx=1; STATUS reads 32'h0000_0002 (empty); BAUDDIV reads 433.
- Single byte: write BAUDDIV=3, write TXDATA=8'hA5 → after push, uart_tx shows 0 (4 clk), then bits 1,0,1,0,0,1,0,1 (4 clk each), then 1 (4 clk); busy=1 throughout, then 0.
- Fill and overflow: DIV=100, write 17 bytes back-to-back → first byte popped, remaining 16 fill the FIFO; STATUS shows full=1, count=16. An 18th write while full sets overflow=1 and drops the byte. W1C write of 32'h8 clears overflow.
- Back-to-back frames: DIV=1, push 8'h00 and 8'hFF → STOP of frame 1 is followed by exactly 1 IDLE clock before START of frame 2; second frame data all 1s.
- Reset mid-frame: DIV=7, push 8'h00, assert rst during DATA bit 3 → uart_tx goes 1 asynchronously; after release, STATUS=empty, not busy.
- Decode: read at BASE_ADDR+0xC and at 32'h0000_1004 → ext_data_out=0; write 8'h55 to BASE_ADDR+0x20 → no FIFO push, count stays 0.
